// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier datapath.
package booth_pkg;

  localparam int unsigned BoothWidth = 8;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_t;

  // {q0, q_m1}: 01 -> add M, 10 -> subtract M, 00/11 -> nothing.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    booth_op_t op;
    case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: optional add/sub of M, then arithmetic right shift.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned Width = BoothWidth
) (
  input  logic [Width:0]   a_i,
  input  logic [Width:0]   m_i,
  input  logic [Width-1:0] q_i,
  input  logic             q_m1_i,
  input  booth_op_t        op_i,
  output logic [Width:0]   a_o,
  output logic [Width-1:0] q_o,
  output logic             q_m1_o
);

  logic [Width:0] sum;

  always_comb begin
    sum = a_i;
    case (op_i)
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
  end

  // Old q_m1 falls off the bottom; the sign bit of the sum is replicated at the top.
  always_comb begin
    {a_o, q_o, q_m1_o} = {sum[Width], sum, q_i};
  end

  logic unused_q_m1;
  assign unused_q_m1 = q_m1_i;

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath driven by controller enables (load / iterate / capture).
module booth_datapath
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BoothWidth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               en_i,
  input  logic               en_pp,
  input  logic               en_fp,
  output logic               count,
  output logic [2*WIDTH-1:0] product,
  output logic               valid
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_m1_q, q_m1_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               valid_q, valid_d;

  logic [WIDTH:0]     step_a;
  logic [WIDTH-1:0]   step_q;
  logic               step_q_m1;
  booth_op_t          step_op;

  assign step_op = booth_decode(q_q[0], q_m1_q);

  booth_step #(
    .Width (WIDTH)
  ) u_step (
    .a_i    (a_q),
    .m_i    (m_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .op_i   (step_op),
    .a_o    (step_a),
    .q_o    (step_q),
    .q_m1_o (step_q_m1)
  );

  assign count   = (cnt_q == CntMax);
  assign product = product_q;
  assign valid   = valid_q;

  // Only the highest-priority enable acts: en_i > en_pp > en_fp.
  always_comb begin
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    q_m1_d    = q_m1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    valid_d   = 1'b0;
    if (en_i) begin
      m_d    = {multiplicand[WIDTH-1], multiplicand};
      q_d    = multiplier;
      a_d    = '0;
      q_m1_d = 1'b0;
      cnt_d  = '0;
    end else if (en_pp) begin
      if (!count) begin
        a_d    = step_a;
        q_d    = step_q;
        q_m1_d = step_q_m1;
        cnt_d  = cnt_q + 1'b1;
      end
    end else if (en_fp) begin
      product_d = {a_q[WIDTH-1:0], q_q};
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q_m1_q    <= q_m1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_booth_datapath.sv
// Randomised scoreboard bench for booth_datapath against a plain signed-multiply model.
module tb_booth_datapath;

  localparam int unsigned W = 8;

  logic             clk;
  logic             reset;
  logic [W-1:0]     multiplicand;
  logic [W-1:0]     multiplier;
  logic             en_i;
  logic             en_pp;
  logic             en_fp;
  logic             count;
  logic [2*W-1:0]   product;
  logic             valid;

  booth_datapath #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .en_i         (en_i),
    .en_pp        (en_pp),
    .en_fp        (en_fp),
    .count        (count),
    .product      (product),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_pulses = 0;
  int n_pushed = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_prod;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: full-precision signed product truncated to 2*W bits.
  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [2*W-1:0] sm;
    logic signed [2*W-1:0] sq;
    sm = $signed(m);
    sq = $signed(q);
    return sm * sq;
  endfunction

  // Monitor: every valid pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got product 0x%0h, expected no pulse", product);
      end else begin
        check("product", {48'd0, product}, {48'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] m, input logic [W-1:0] q, input logic with_pp);
    multiplicand = m;
    multiplier   = q;
    en_i  = 1'b1;
    en_pp = with_pp;
    tick();
    en_i  = 1'b0;
    en_pp = 1'b0;
    check("count_after_load", {63'd0, count}, 64'd0);
    check("product_hold_on_load", {48'd0, product}, {48'd0, last_prod});
  endtask

  task automatic iterate(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      if (noisy && $urandom_range(0, 3) == 0) tick();
      en_pp = 1'b1;
      en_fp = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      en_pp = 1'b0;
      en_fp = 1'b0;
    end
  endtask

  task automatic capture(input logic [2*W-1:0] expv);
    exp_q.push_back(expv);
    n_pushed++;
    en_fp = 1'b1;
    tick();
    en_fp = 1'b0;
    last_prod = expv;
  endtask

  task automatic run_mult(input logic [W-1:0] m, input logic [W-1:0] q, input bit noisy);
    load(m, q, 1'b0);
    iterate(W - 1, noisy);
    check("count_before_last", {63'd0, count}, 64'd0);
    iterate(1, noisy);
    check("count_after_last", {63'd0, count}, 64'd1);
    if (noisy) repeat ($urandom_range(0, 2)) tick();
    capture(model_mul(m, q));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    multiplicand = '0;
    multiplier   = '0;
    en_i = 1'b0;
    en_pp = 1'b0;
    en_fp = 1'b0;
    last_prod = '0;
    tick();
    check("reset_count", {63'd0, count}, 64'd0);
    check("reset_product", {48'd0, product}, 64'd0);
    check("reset_valid", {63'd0, valid}, 64'd0);
    reset = 1'b0;
    tick();

    run_mult(8'd3, 8'd5, 1'b0);
    run_mult(8'h80, 8'h80, 1'b0);
    run_mult(8'hF9, 8'd6, 1'b0);
    run_mult(8'd127, 8'hFF, 1'b0);

    // Overrun: extra iterations after count must change nothing.
    load(8'hF9, 8'd6, 1'b0);
    iterate(W, 1'b0);
    iterate(3, 1'b0);
    check("count_after_overrun", {63'd0, count}, 64'd1);
    capture(model_mul(8'hF9, 8'd6));
    tick();

    // Asynchronous reset mid-iteration.
    load(8'd100, 8'd77, 1'b0);
    iterate(4, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midreset_count", {63'd0, count}, 64'd0);
    check("midreset_product", {48'd0, product}, 64'd0);
    check("midreset_valid", {63'd0, valid}, 64'd0);
    last_prod = '0;
    tick();
    reset = 1'b0;
    tick();
    run_mult(8'd2, 8'd2, 1'b0);

    // Restart with en_i and en_pp together; the load must win.
    load(8'd3, 8'd5, 1'b0);
    iterate(4, 1'b0);
    load(8'hFF, 8'hFF, 1'b1);
    iterate(W, 1'b0);
    check("count_after_restart", {63'd0, count}, 64'd1);
    capture(model_mul(8'hFF, 8'hFF));
    tick();

    for (int k = 0; k < 25; k++) begin
      run_mult(W'($urandom), W'($urandom), 1'b1);
    end

    repeat (3) tick();
    check("pulse_count", 64'(n_pulses), 64'(n_pushed));
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
